// File: rtl/memory_value_serializer_pkg.sv
// Shared types and helpers for the memory value serializer.
package memory_pkg;

  typedef enum logic {SER_IDLE, SER_STREAM} ser_state_t;

  // Requests longer than the stored value are clamped to the full value.
  function automatic int clamp_beats(input int len, input int num_beats);
    return (len > num_beats) ? num_beats : len;
  endfunction

endpackage

// File: rtl/memory_value_serializer_if.sv
// Beat stream from the serializer toward the response encoder.
interface memory_value_serializer_if #(
  parameter int BEAT_WIDTH = 8
);
  // A beat transfers on any rising clk edge where out_valid & out_ready; once
  // out_valid is high, out_data/out_last hold and out_valid stays high until that edge.
  logic [BEAT_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/memory_value_serializer_shift_reg.sv
// Value shift register presenting one beat at a time.
// Beat order is LSB-first unless MEMORY_SERIALIZER_MSB_FIRST_EN is defined.
module serializer_shift_reg #(
  parameter int VALUE_WIDTH = 64,
  parameter int BEAT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   shift,
  input  logic [VALUE_WIDTH-1:0] load_value,
  output logic [BEAT_WIDTH-1:0]  beat
);

  logic [VALUE_WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_value;
    end else if (shift) begin
`ifdef MEMORY_SERIALIZER_MSB_FIRST_EN
      sr <= sr << BEAT_WIDTH;
`else
      sr <= sr >> BEAT_WIDTH;
`endif
    end
  end

`ifdef MEMORY_SERIALIZER_MSB_FIRST_EN
  assign beat = sr[VALUE_WIDTH-1 -: BEAT_WIDTH];
`else
  assign beat = sr[BEAT_WIDTH-1:0];
`endif

endmodule

// File: rtl/memory_value_serializer.sv
// Latches a stored value on start and streams it out as beats with last/done.
// Optional MEMORY_SERIALIZER_MSB_FIRST_EN selects MSB-first beat order.
module memory_value_serializer
  import memory_pkg::*;
#(
  parameter int VALUE_WIDTH = 64,
  parameter int BEAT_WIDTH  = 8,
  localparam int NUM_BEATS  = VALUE_WIDTH / BEAT_WIDTH,
  localparam int LEN_W      = $clog2(NUM_BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [VALUE_WIDTH-1:0]    value_in,
  input  logic [LEN_W-1:0]          length_in,
  output logic                      busy,
  output logic                      done,
  output ser_state_t                state_dbg,
  memory_value_serializer_if.master out_if
);

  ser_state_t       state, state_next;
  logic [LEN_W-1:0] count, count_next;
  logic             done_next;
  logic             load, shift;
  logic [BEAT_WIDTH-1:0] beat;

  serializer_shift_reg #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .BEAT_WIDTH  (BEAT_WIDTH)
  ) u_shift_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .shift      (shift),
    .load_value (value_in),
    .beat       (beat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SER_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
    end
  end

  // Start is only looked at in IDLE, so a start during a transfer is dropped.
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      SER_IDLE: begin
        if (start) begin
          if (length_in == '0) begin
            done_next = 1'b1;
          end else begin
            load       = 1'b1;
            count_next = LEN_W'(clamp_beats(int'(length_in), NUM_BEATS));
            state_next = SER_STREAM;
          end
        end
      end
      SER_STREAM: begin
        if (out_if.out_ready) begin
          shift      = 1'b1;
          count_next = count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            done_next  = 1'b1;
            state_next = SER_IDLE;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  assign busy             = (state == SER_STREAM);
  assign state_dbg        = state;
  assign out_if.out_valid = (state == SER_STREAM);
  assign out_if.out_last  = (state == SER_STREAM) && (count == LEN_W'(1));
  assign out_if.out_data  = beat;

endmodule

// File: tb/tb_memory_value_serializer.sv
// Directed bench for memory_value_serializer at VALUE_WIDTH=32, BEAT_WIDTH=8.
module tb_memory_value_serializer;
  import memory_pkg::*;

  localparam int VW = 32;
  localparam int BW = 8;
  localparam int LW = 3;

  typedef struct {
    logic [VW-1:0] value;
    logic [LW-1:0] len;
    int            n;
    logic [BW-1:0] beats [4];
    bit            alt_ready;
    bit            inject;
    bit            b2b;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] value_in = '0;
  logic [LW-1:0] length_in = '0;
  logic          busy, done;
  ser_state_t    state_dbg;
  int            checks = 0;
  int            errors = 0;
  vec_t          vecs [8];

  memory_value_serializer_if #(.BEAT_WIDTH(BW)) ser_if ();

  memory_value_serializer #(.VALUE_WIDTH(VW), .BEAT_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .value_in  (value_in),
    .length_in (length_in),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .out_if    (ser_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    ser_if.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(ser_if.out_valid), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_vec(input vec_t v);
    int k;
    int cyc;
    start     = 1'b1;
    value_in  = v.value;
    length_in = v.len;
    @(negedge clk);
    start = 1'b0;
    if (v.n == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_valid", 32'(ser_if.out_valid), 0);
      chk("zero_busy", 32'(busy), 0);
      return;
    end
    k   = 0;
    cyc = 0;
    while (k < v.n && cyc < 40) begin
      chk("beat_valid", 32'(ser_if.out_valid), 1);
      chk("beat_busy", 32'(busy), 1);
      chk("beat_done", 32'(done), 0);
      chk("beat_data", 32'(ser_if.out_data), 32'(v.beats[k]));
      chk("beat_last", 32'(ser_if.out_last), (k == v.n - 1) ? 1 : 0);
      if (v.inject && cyc == 1) begin
        start     = 1'b1;
        value_in  = 32'h11223344;
        length_in = 3'd4;
      end else begin
        start = 1'b0;
      end
      ser_if.out_ready = v.alt_ready ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      if (ser_if.out_ready) k++;
      cyc++;
    end
    start = 1'b0;
    chk("beat_count", 32'(k), 32'(v.n));
    chk("end_done", 32'(done), 1);
    chk("end_valid", 32'(ser_if.out_valid), 0);
    chk("end_busy", 32'(busy), 0);
  endtask

  initial begin
    ser_if.out_ready = 1'b0;
`ifdef MEMORY_SERIALIZER_MSB_FIRST_EN
    vecs[0] = '{32'hA1B2C3D4, 3'd4, 4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hA1B2C3D4, 3'd4, 4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hA1B2C3D4, 3'd2, 2, '{8'hA1, 8'hB2, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hA1B2C3D4, 3'd7, 4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hA1B2C3D4, 3'd0, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hA1B2C3D4, 3'd4, 4, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h11223344, 3'd4, 4, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'hA1B2C3D4, 3'd1, 1, '{8'hA1, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0};
`else
    vecs[0] = '{32'hA1B2C3D4, 3'd4, 4, '{8'hD4, 8'hC3, 8'hB2, 8'hA1}, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hA1B2C3D4, 3'd4, 4, '{8'hD4, 8'hC3, 8'hB2, 8'hA1}, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hA1B2C3D4, 3'd2, 2, '{8'hD4, 8'hC3, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hA1B2C3D4, 3'd7, 4, '{8'hD4, 8'hC3, 8'hB2, 8'hA1}, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hA1B2C3D4, 3'd0, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hA1B2C3D4, 3'd4, 4, '{8'hD4, 8'hC3, 8'hB2, 8'hA1}, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h11223344, 3'd4, 4, '{8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'hA1B2C3D4, 3'd1, 1, '{8'hD4, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(ser_if.out_valid), 0);
    chk("rst_last", 32'(ser_if.out_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(ser_if.out_data), 0);
    chk("rst_state", 32'(state_dbg), 32'(SER_IDLE));
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].b2b) idle(2);
      run_vec(vecs[i]);
    end
    idle(2);

    // Reset asserted mid-stream after two beats
    ser_if.out_ready = 1'b1;
    start     = 1'b1;
    value_in  = 32'hA1B2C3D4;
    length_in = 3'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_valid_before", 32'(ser_if.out_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(ser_if.out_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    rst_n = 1'b1;
    idle(3);
    run_vec(vecs[0]);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_value_serializer.md
# memory_value_serializer

Read-side counterpart to the value register arrays in the cache memory. It latches one stored value of VALUE_WIDTH bits on a start pulse and streams it out as BEAT_WIDTH-bit beats over a valid/ready interface toward the response path. It asserts last on the final beat and pulses done on completion. It sits between the memory value store and the protocol response encoder.

## Interface
Parameters:
- VALUE_WIDTH, 64: width of the stored value; must be a multiple of BEAT_WIDTH.
- BEAT_WIDTH, 8: width of one output beat.
- Derived: NUM_BEATS = VALUE_WIDTH/BEAT_WIDTH; LEN_W = $clog2(NUM_BEATS+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request to serialize value_in; sampled on the rising clk edge.
- value_in  in  VALUE_WIDTH  value to stream; sampled together with start.
- length_in  in  LEN_W  number of beats to emit; sampled together with start.
- busy  out  1  high while a transfer is in progress.
- out_data  out  BEAT_WIDTH  current beat.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  current beat is the final beat of the transfer.
- done  out  1  one-cycle pulse after the final handshake, or after a zero-length start.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - STREAM: beats pending.
- IDLE transitions on start:
  - length_in == 0: remain in IDLE; done=1 in the next cycle; no beats are emitted.
  - Otherwise: latch value_in into the shift register and load the beat counter with min(length_in, NUM_BEATS). A length_in greater than NUM_BEATS is clamped. Go to STREAM.
- STREAM behaviour:
  - out_valid=1; out_data is the current low beat of the shift register.
  - out_last=1 when the counter equals 1.
- Handshake (out_valid & out_ready):
  - Shift the register by BEAT_WIDTH and decrement the counter.
  - If it was the last beat: go to IDLE and set done=1 for the next cycle.
- Beat order is LSB-first by default: beat k = value[k*BEAT_WIDTH +: BEAT_WIDTH].
- A start while busy=1 is ignored; it is neither queued nor does it corrupt the transfer.
- out_ready while out_valid=0 has no effect.
- busy = (state == STREAM).

## Timing
- Reset: all outputs are 0 (busy, out_valid, out_last, done, out_data), state IDLE, counter 0.
- Reset asserted mid-stream: out_valid drops in the next cycle, no done pulse, and the partial transfer is discarded.
- Start sampled at edge N: out_valid=1 with beat 0 from N+1.
- Throughput: 1 beat per cycle while out_ready=1. All outputs are registered.
- Backpressure: out_data and out_last stay stable while out_valid & !out_ready. out_valid never drops before the handshake.
- Final handshake at edge M: at M+1, out_valid=0, busy=0, done=1. A start sampled at M+1 is accepted, giving a back-to-back transfer with one idle cycle.
- Zero-length start at edge N: done=1 at N+1; busy stays 0.
- Latency for L beats with out_ready held high: done at N+L+1.

## Configuration
- MEMORY_SERIALIZER_MSB_FIRST_EN defined:
  - Beat 0 = value[VALUE_WIDTH-1 -: BEAT_WIDTH].
  - The shift register shifts left; out_data is taken from the top beat.
  - length_in < NUM_BEATS emits the top length_in beats.
- Not defined: LSB-first order as described in Operation.
- Timing and handshake are identical in both builds.

## Structure
- memory_pkg holds:
  - typedef enum logic {SER_IDLE, SER_STREAM} ser_state_t.
  - A function computing the clamped beat count.
- Sub-module serializer_shift_reg (parameters VALUE_WIDTH, BEAT_WIDTH; inputs load, shift, load_value; output beat). It contains the shift direction selection controlled by the macro.
- The top level contains the FSM, beat counter, done pulse and handshake logic.

## Test plan
All scenarios use VALUE_WIDTH=32, BEAT_WIDTH=8, value 0xA1B2C3D4.
- Length 4, out_ready=1, start at N → beats D4,C3,B2,A1 at N+1..N+4; out_last only on A1; done=1 at N+5; busy high N+1..N+4.
- Length 4, out_ready low on alternate cycles → out_data and out_last held stable while stalled; exactly 4 handshakes; done one cycle after the A1 handshake.
- Length 2 → beats D4,C3 (out_last on C3). Length 7 → clamped to 4 beats. Length 0 → no out_valid; done=1 at N+1.
- Second start with 0x11223344 during the transfer → ignored; output matches the first value. Start at the cycle after done → new transfer begins normally.
- rst_n low after 2 beats → out_valid=0 and busy=0 on the next cycle; no done pulse; a subsequent start works.
- MSB_FIRST build, length 4 → A1,B2,C3,D4. Length 2 → A1,B2.
